// File: rtl/jogo_pkg.sv
// Shared types and widths for the guessing-game datapath.
// Holds the round FSM state encoding and the signed-difference helper.
package jogo_pkg;

    localparam int LARG_DIGITO = 4;
    localparam int LARG_DIFF   = 5;

    typedef enum logic [2:0] {
        ESPERA_SENHA,
        ESPERA_TENT,
        CALCULA,
        APRESENTA,
        FIM
    } estado_t;

    // Zero-extend both digits so the 5-bit result covers -15..+15 without overflow
    function automatic logic [LARG_DIFF-1:0] subtrai(
        input logic [LARG_DIGITO-1:0] palpite,
        input logic [LARG_DIGITO-1:0] segredo
    );
        return {1'b0, palpite} - {1'b0, segredo};
    endfunction

endpackage

// File: rtl/gerador_tentativa_if.sv
// Button/value inputs, comparator feedback and round outputs of the guess generator.
// The master side is the board/testbench; the slave side is gerador_tentativa.
interface gerador_tentativa_if;
    import jogo_pkg::*;

    logic [LARG_DIGITO-1:0] senha_in;
    logic                   grava_senha;
    logic [LARG_DIGITO-1:0] tentativa_in;
    logic                   confirma;
    logic                   igual_in;
    logic [LARG_DIGITO-1:0] diff;
    logic                   sinal;
    logic                   valido;
    logic [2:0]             tentativas;
    logic                   acertou;
    logic                   bloqueado;

    modport master (
        output senha_in, grava_senha, tentativa_in, confirma, igual_in,
        input  diff, sinal, valido, tentativas, acertou, bloqueado
    );

    modport slave (
        input  senha_in, grava_senha, tentativa_in, confirma, igual_in,
        output diff, sinal, valido, tentativas, acertou, bloqueado
    );

endinterface

// File: rtl/detector_borda.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Pulse appears 3 clocks after the raw rise; a held button yields a single pulse.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic i_botao,
    output logic o_pulso
);

    logic r_sinc1;
    logic r_sinc2;
    logic r_anterior;
    logic r_pulso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sinc1    <= 1'b0;
            r_sinc2    <= 1'b0;
            r_anterior <= 1'b0;
            r_pulso    <= 1'b0;
        end else begin
            r_sinc1    <= i_botao;
            r_sinc2    <= r_sinc1;
            r_anterior <= r_sinc2;
            r_pulso    <= r_sinc2 & ~r_anterior;
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/gerador_tentativa.sv
// Round controller: stores the secret, captures guesses, presents guess-secret and tracks attempts.
// valido comes 5 clocks after a raw confirma rise; presses outside the accepting states are dropped.
module gerador_tentativa
    import jogo_pkg::*;
#(
    parameter int MAX_TENT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    gerador_tentativa_if.slave bus
);

    localparam logic [2:0] L_MAX_TENT = 3'(MAX_TENT);

    estado_t r_estado;
    estado_t w_prox_estado;

    logic [LARG_DIGITO-1:0] r_senha;
    logic [LARG_DIGITO-1:0] r_diff;
    logic                   r_sinal;
    logic [2:0]             r_tentativas;
    logic                   r_acertou;
    logic                   r_bloqueado;

    logic       w_pulso_grava;
    logic       w_pulso_confirma;
    logic       w_inicia_rodada;
    logic       w_calcula;
    logic       w_apresenta;
    logic       w_acerto;
    logic       w_esgotou;
    logic [2:0] w_tent_inc;

    detector_borda u_borda_grava (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_botao (bus.grava_senha),
        .o_pulso (w_pulso_grava)
    );

    detector_borda u_borda_confirma (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_botao (bus.confirma),
        .o_pulso (w_pulso_confirma)
    );

    assign w_tent_inc = (r_tentativas >= L_MAX_TENT) ? L_MAX_TENT : r_tentativas + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ESPERA_SENHA;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // grava_senha is checked first everywhere so it wins over a simultaneous confirma
    always_comb begin
        w_prox_estado   = r_estado;
        w_inicia_rodada = 1'b0;
        w_calcula       = 1'b0;
        w_apresenta     = 1'b0;
        w_acerto        = 1'b0;
        w_esgotou       = 1'b0;
        case (r_estado)
            ESPERA_SENHA, FIM: begin
                if (w_pulso_grava) begin
                    w_inicia_rodada = 1'b1;
                    w_prox_estado   = ESPERA_TENT;
                end
            end
            ESPERA_TENT: begin
                if (w_pulso_grava) begin
                    w_inicia_rodada = 1'b1;
                    w_prox_estado   = ESPERA_TENT;
                end else if (w_pulso_confirma) begin
                    w_prox_estado = CALCULA;
                end
            end
            CALCULA: begin
                w_calcula     = 1'b1;
                w_prox_estado = APRESENTA;
            end
            APRESENTA: begin
                w_apresenta = 1'b1;
                if (bus.igual_in) begin
                    w_acerto      = 1'b1;
                    w_prox_estado = FIM;
                end else if (w_tent_inc == L_MAX_TENT) begin
                    w_esgotou     = 1'b1;
                    w_prox_estado = FIM;
                end else begin
                    w_prox_estado = ESPERA_TENT;
                end
            end
            default: begin
                w_prox_estado = ESPERA_SENHA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_senha      <= '0;
            r_diff       <= '0;
            r_sinal      <= 1'b0;
            r_tentativas <= '0;
            r_acertou    <= 1'b0;
            r_bloqueado  <= 1'b0;
        end else begin
            if (w_inicia_rodada) begin
                r_senha      <= bus.senha_in;
                r_tentativas <= '0;
                r_acertou    <= 1'b0;
                r_bloqueado  <= 1'b0;
            end
            if (w_calcula) begin
                {r_sinal, r_diff} <= subtrai(bus.tentativa_in, r_senha);
            end
            if (w_apresenta) begin
                r_tentativas <= w_tent_inc;
                if (w_acerto) begin
                    r_acertou <= 1'b1;
                end
                if (w_esgotou) begin
                    r_bloqueado <= 1'b1;
                end
            end
        end
    end

    assign bus.diff       = r_diff;
    assign bus.sinal      = r_sinal;
    assign bus.valido     = (r_estado == APRESENTA);
    assign bus.tentativas = r_tentativas;
    assign bus.acertou    = r_acertou;
    assign bus.bloqueado  = r_bloqueado;

endmodule

// File: tb/tb_gerador_tentativa.sv
// Randomized and directed bench for gerador_tentativa with a cycle model of the round rules.
// The comparator feedback is emulated from the DUT outputs (igual = difference is zero).
module tb_gerador_tentativa;

    localparam int MAX = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gerador_tentativa_if ifc ();

    gerador_tentativa #(.MAX_TENT(MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    assign ifc.igual_in = (ifc.diff == 4'd0) && !ifc.sinal;

    int n_vec = 0;
    int n_err = 0;

    // Model: round phase 0 = no open round, 1 = taking guesses, 2 = guess captured, 3 = result shown
    int         m_fase;
    logic [3:0] m_segredo;
    logic [3:0] m_diff;
    logic       m_sinal;
    logic       m_acertou;
    logic       m_bloqueado;
    int         m_tent;
    bit         hist_g[4];
    bit         hist_c[4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fase = 0; m_segredo = 0; m_diff = 0; m_sinal = 0;
            m_acertou = 0; m_bloqueado = 0; m_tent = 0;
            for (int i = 0; i < 4; i++) begin hist_g[i] = 0; hist_c[i] = 0; end
        end else begin
            bit pg, pc;
            // A raw level seen at edge n becomes a usable press at edge n+3
            pg = hist_g[2] && !hist_g[3];
            pc = hist_c[2] && !hist_c[3];
            for (int i = 3; i > 0; i--) begin hist_g[i] = hist_g[i-1]; hist_c[i] = hist_c[i-1]; end
            hist_g[0] = ifc.grava_senha;
            hist_c[0] = ifc.confirma;
            if ((m_fase == 0 || m_fase == 1) && pg) begin
                m_segredo = ifc.senha_in; m_tent = 0; m_acertou = 0; m_bloqueado = 0; m_fase = 1;
            end else if (m_fase == 1 && pc) begin
                m_fase = 2;
            end else if (m_fase == 2) begin
                int d;
                d = int'(ifc.tentativa_in) - int'(m_segredo);
                {m_sinal, m_diff} = 5'(d);
                m_fase = 3;
            end else if (m_fase == 3) begin
                m_tent = (m_tent < MAX) ? m_tent + 1 : MAX;
                if (m_diff == 0 && !m_sinal) begin
                    m_acertou = 1; m_fase = 0;
                end else if (m_tent == MAX) begin
                    m_bloqueado = 1; m_fase = 0;
                end else begin
                    m_fase = 1;
                end
            end
        end
    end

    task automatic compara_ciclo();
        logic exp_v;
        exp_v = (m_fase == 3);
        n_vec++;
        if (ifc.diff !== m_diff || ifc.sinal !== m_sinal || ifc.valido !== exp_v ||
            ifc.tentativas !== 3'(m_tent) || ifc.acertou !== m_acertou || ifc.bloqueado !== m_bloqueado) begin
            n_err++;
            $display("FAIL ciclo t=%0t dut diff=%h sinal=%b valido=%b tent=%0d ac=%b bl=%b / esperado diff=%h sinal=%b valido=%b tent=%0d ac=%b bl=%b",
                     $time, ifc.diff, ifc.sinal, ifc.valido, ifc.tentativas, ifc.acertou, ifc.bloqueado,
                     m_diff, m_sinal, exp_v, m_tent, m_acertou, m_bloqueado);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) compara_ciclo();
    endtask

    task automatic chk(input string nome, input int obtido, input int esperado);
        n_vec++;
        if (obtido != esperado) begin
            n_err++;
            $display("FAIL %s obtido=%0d esperado=%0d", nome, obtido, esperado);
        end
    endtask

    task automatic aperta(input bit conf, input logic [3:0] val, input int segura, input int janela,
                          output int nval, output logic [3:0] d, output logic s);
        nval = 0; d = 4'h0; s = 1'b0;
        if (conf) begin ifc.tentativa_in = val; ifc.confirma = 1'b1; end
        else begin ifc.senha_in = val; ifc.grava_senha = 1'b1; end
        for (int i = 0; i < janela; i++) begin
            tick();
            if (i == segura - 1) begin ifc.confirma = 1'b0; ifc.grava_senha = 1'b0; end
            if (ifc.valido) begin nval++; d = ifc.diff; s = ifc.sinal; end
        end
    endtask

    task automatic chk_reset(input string nome);
        chk({nome, "_diff"}, int'(ifc.diff), 0);
        chk({nome, "_sinal"}, int'(ifc.sinal), 0);
        chk({nome, "_valido"}, int'(ifc.valido), 0);
        chk({nome, "_tent"}, int'(ifc.tentativas), 0);
        chk({nome, "_flags"}, int'({ifc.acertou, ifc.bloqueado}), 0);
    endtask

    initial begin
        int nv;
        logic [3:0] d;
        logic s;
        bit achou;

        ifc.senha_in = 0; ifc.grava_senha = 0; ifc.tentativa_in = 0; ifc.confirma = 0;
        #2 chk_reset("reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        aperta(1, 4'd3, 2, 10, nv, d, s);
        chk("conf_sem_senha_valido", nv, 0);

        aperta(0, 4'd5, 2, 6, nv, d, s);
        aperta(1, 4'd5, 2, 10, nv, d, s);
        chk("acerto_valido", nv, 1);
        chk("acerto_diff", int'({s, d}), 0);
        chk("acerto_tent", int'(ifc.tentativas), 1);
        chk("acerto_flag", int'(ifc.acertou), 1);

        aperta(0, 4'd9, 2, 6, nv, d, s);
        chk("nova_rodada_tent", int'(ifc.tentativas), 0);
        aperta(1, 4'd7, 2, 10, nv, d, s);
        chk("7m9_sinal_diff", int'({s, d}), 5'b11110);
        aperta(1, 4'd12, 2, 10, nv, d, s);
        chk("12m9_sinal_diff", int'({s, d}), 5'b00011);
        aperta(1, 4'd3, 2, 10, nv, d, s);
        chk("esgotou_bloq", int'(ifc.bloqueado), 1);
        chk("esgotou_tent", int'(ifc.tentativas), 3);
        aperta(1, 4'd9, 2, 10, nv, d, s);
        chk("bloqueado_sem_valido", nv, 0);

        aperta(0, 4'd15, 2, 6, nv, d, s);
        chk("reinicio_tent", int'(ifc.tentativas), 0);
        chk("reinicio_bloq", int'(ifc.bloqueado), 0);
        aperta(1, 4'd0, 2, 10, nv, d, s);
        chk("0m15_sinal_diff", int'({s, d}), 5'b10001);

        aperta(1, 4'd4, 50, 60, nv, d, s);
        chk("segurado_um_valido", nv, 1);

        ifc.senha_in = 4'd2; ifc.tentativa_in = 4'd7;
        ifc.grava_senha = 1'b1; ifc.confirma = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 1) begin ifc.grava_senha = 1'b0; ifc.confirma = 1'b0; end
            if (ifc.valido) nv++;
        end
        chk("simultaneo_valido", nv, 0);
        chk("simultaneo_tent", int'(ifc.tentativas), 0);
        aperta(1, 4'd5, 2, 10, nv, d, s);
        chk("5m2_sinal_diff", int'({s, d}), 5'b00011);

        aperta(0, 4'd8, 2, 6, nv, d, s);
        ifc.tentativa_in = 4'd1; ifc.confirma = 1'b1;
        achou = 0;
        for (int i = 0; i < 10 && !achou; i++) begin
            tick();
            if (m_fase == 2) achou = 1;
        end
        chk("chegou_calcula", int'(achou), 1);
        #1 rst_n = 1'b0;
        ifc.confirma = 1'b0;
        #1 chk_reset("reset_calcula");
        @(negedge clk);
        #1 rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifc.valido) nv++;
        end
        chk("pos_reset_sem_valido", nv, 0);

        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(0, 2) == 0) ifc.confirma = ~ifc.confirma;
            if ($urandom_range(0, 29) == 0) ifc.grava_senha = ~ifc.grava_senha;
            if ($urandom_range(0, 3) == 0) ifc.tentativa_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ifc.senha_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1499) == 0) begin
                #($urandom_range(1, 2));
                rst_n = 1'b0;
                #1 chk_reset("reset_aleatorio");
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
